// File: rtl/dsram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsram_pkg
//  Description : Shared types and constants for the data-side SRAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsram_pkg;

  // Width of the wait-state counter (holds LATENCY-1, LATENCY <= 15)
  localparam int DSRAM_CNT_W  = 4;
  // Width of one byte lane of the data word
  localparam int DSRAM_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dsram_state_e;

  // Expand a 4-bit byte enable into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*DSRAM_BYTE_W +: DSRAM_BYTE_W] = {DSRAM_BYTE_W{be[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dsram_bank
//  Description : 2^ADDR_W x 32 word memory with per-byte write mask and a
//                synchronous, enable-qualified read port. The read register
//                holds its value until the next enabled read. A read and a
//                write to the same word in one cycle return the old word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsram_bank
  import dsram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*DSRAM_BYTE_W +: DSRAM_BYTE_W] <= wdata[i*DSRAM_BYTE_W +: DSRAM_BYTE_W];
      end
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dsram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dsram_resp
//  Description : Data-side SRAM responder. Captures a MEM-stage request,
//                waits LATENCY cycles, commits against the local bank and
//                returns a single rvalid_o pulse. Stalls the pipeline while
//                the access is outstanding; cancel aborts uncommitted work.
//                Optional macro DSRAM_RANGE_CHECK_EN flags addresses beyond
//                the array (err_o) instead of letting them alias.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsram_resp
  import dsram_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_en,
  input  logic [3:0]  req_ren,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        cancel,
  output logic        stall_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  dsram_state_e           state_q, state_d;
  logic [DSRAM_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]      word_q, word_d;
  logic [3:0]             ren_q, ren_d;
  logic [3:0]             wen_q, wen_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   oor_q, oor_d;
  logic [31:0]            rmask_q, rmask_d;
  logic                   err_q, err_d;
  logic                   commit;
  logic                   req_oor;
  logic                   unused_addr;
  logic [31:0]            bank_rdata;

`ifdef DSRAM_RANGE_CHECK_EN
  assign req_oor     = |req_addr[31:ADDR_W+2];
  assign unused_addr = ^req_addr[1:0];
`else
  // Upper address bits are dropped so the address wraps modulo the depth
  assign req_oor     = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  // Next-state, request capture and commit-time output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    rmask_d = rmask_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_en && !cancel) begin
          word_d  = req_addr[ADDR_W+1:2];
          ren_d   = req_ren;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          oor_d   = req_oor;
          cnt_d   = DSRAM_CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Out-of-range accesses return zero data and never write
          commit  = 1'b1;
          rmask_d = oor_q ? 32'h0 : byte_mask(ren_q);
          err_d   = oor_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      ren_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      rmask_q <= rmask_d;
      err_q   <= err_d;
    end
  end

  dsram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .re    (commit),
    .we    ((commit && !oor_q) ? wen_q : 4'h0),
    .addr  (word_q),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  // The bank holds the last committed word; the mask register zeroes
  // disabled lanes and forces zero after reset or an out-of-range access.
  assign rdata_o  = bank_rdata & rmask_q;
  assign err_o    = err_q;
  assign rvalid_o = (state_q == ST_RESP) && !cancel;
  assign stall_o  = resetn && req_en && !cancel && (state_q != ST_RESP);

endmodule
`default_nettype wire
